// File: rtl/dbrk_arb_if.sv
// Bus bundle between the data-break arbiter and its CPU/device/memory environment.
// The master drives requests, CPU state and read data. The slave is the arbiter.
interface dbrk_arb_if #(
  parameter int unsigned NREQ = 4
);
  logic [4:0]         state;
  logic [NREQ-1:0]    brk_req;
  logic [NREQ-1:0]    brk_write;
  logic [15*NREQ-1:0] brk_addr;
  logic [12*NREQ-1:0] brk_wdata;
  logic [11:0]        mem_rdata;
  logic               cpu_hold;
  logic               brk_active;
  logic [14:0]        mem_addr;
  logic [11:0]        mem_wdata;
  logic               mem_we;
  logic [NREQ-1:0]    brk_ack;
  logic [11:0]        brk_rdata;

  modport master (
    output state, brk_req, brk_write, brk_addr, brk_wdata, mem_rdata,
    input  cpu_hold, brk_active, mem_addr, mem_wdata, mem_we, brk_ack, brk_rdata
  );

  modport slave (
    input  state, brk_req, brk_write, brk_addr, brk_wdata, mem_rdata,
    output cpu_hold, brk_active, mem_addr, mem_wdata, mem_we, brk_ack, brk_rdata
  );
endinterface

// File: rtl/dbrk_arb.sv
// Data-break arbiter: holds the CPU at a major-state boundary and serves break devices
// one memory cycle each, in round-robin order, back to back while requests remain.
module dbrk_arb #(
  parameter int unsigned NREQ = 4
) (
  input  logic     clk,
  input  logic     reset,
  dbrk_arb_if.slave bus
);
  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // CPU major-state codes: major*4 + minor, with F=0, D=1, E=2, H=3.
  localparam logic [4:0] ST_F3 = 5'd3;
  localparam logic [4:0] ST_D3 = 5'd7;
  localparam logic [4:0] ST_E3 = 5'd11;
  localparam logic [4:0] ST_H0 = 5'd12;
  localparam logic [4:0] ST_H1 = 5'd13;
  localparam logic [4:0] ST_H2 = 5'd14;
  localparam logic [4:0] ST_H3 = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ADDR,
    S_DATA,
    S_ACK
  } st_t;

  st_t st, st_d;

  logic [LW-1:0]   last, last_d;
  logic            wr_flag, wr_flag_d;
  logic            cpu_hold_d, brk_active_d, mem_we_d;
  logic [14:0]     mem_addr_d;
  logic [11:0]     mem_wdata_d, brk_rdata_d;
  logic [NREQ-1:0] brk_ack_d;

  logic            at_boundary;
  logic [NREQ-1:0] excl, cand;
  logic            win_found;
  logic [LW-1:0]   win;
  logic [14:0]     sel_addr;
  logic [11:0]     sel_wdata;
  logic            sel_write;

  always_comb begin
    at_boundary = 1'b0;
    case (bus.state)
      ST_F3, ST_D3, ST_E3, ST_H0, ST_H1, ST_H2, ST_H3: at_boundary = 1'b1;
      default:                                         at_boundary = 1'b0;
    endcase
  end

  // In ACK the device just served is excluded, so it must re-enter through IDLE/HOLD.
  always_comb begin
    excl = '0;
    if (st == S_ACK) excl[last] = 1'b1;
  end

  always_comb begin : arb_pick
    int unsigned k;
    cand      = bus.brk_req & ~excl;
    win_found = 1'b0;
    win       = '0;
    k         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(last) + 1 + i) % NREQ;
      if (!win_found && cand[k[LW-1:0]]) begin
        win_found = 1'b1;
        win       = k[LW-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (LW'(i) == win) begin
        sel_addr  = bus.brk_addr[15*i +: 15];
        sel_wdata = bus.brk_wdata[12*i +: 12];
        sel_write = bus.brk_write[i];
      end
    end
  end

  always_comb begin
    st_d         = st;
    last_d       = last;
    wr_flag_d    = wr_flag;
    cpu_hold_d   = bus.cpu_hold;
    brk_active_d = bus.brk_active;
    mem_we_d     = bus.mem_we;
    mem_addr_d   = bus.mem_addr;
    mem_wdata_d  = bus.mem_wdata;
    brk_rdata_d  = bus.brk_rdata;
    brk_ack_d    = '0;

    case (st)
      S_IDLE: begin
        if (|bus.brk_req) begin
          st_d       = S_HOLD;
          cpu_hold_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (at_boundary) begin
          if (win_found) begin
            st_d         = S_ADDR;
            mem_addr_d   = sel_addr;
            mem_wdata_d  = sel_wdata;
            wr_flag_d    = sel_write;
            brk_active_d = 1'b1;
            last_d       = win;
          end else begin
            st_d       = S_IDLE;
            cpu_hold_d = 1'b0;
          end
        end
      end
      S_ADDR: begin
        st_d     = S_DATA;
        mem_we_d = wr_flag;
      end
      S_DATA: begin
        st_d            = S_ACK;
        mem_we_d        = 1'b0;
        brk_ack_d[last] = 1'b1;
        brk_rdata_d     = wr_flag ? bus.mem_wdata : bus.mem_rdata;
      end
      S_ACK: begin
        if (win_found) begin
          st_d         = S_ADDR;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          wr_flag_d    = sel_write;
          last_d       = win;
        end else begin
          st_d         = S_IDLE;
          cpu_hold_d   = 1'b0;
          brk_active_d = 1'b0;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= st_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last           <= LW'(NREQ - 1);
      wr_flag        <= 1'b0;
      bus.cpu_hold   <= 1'b0;
      bus.brk_active <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.brk_rdata  <= '0;
      bus.brk_ack    <= '0;
    end else begin
      last           <= last_d;
      wr_flag        <= wr_flag_d;
      bus.cpu_hold   <= cpu_hold_d;
      bus.brk_active <= brk_active_d;
      bus.mem_we     <= mem_we_d;
      bus.mem_addr   <= mem_addr_d;
      bus.mem_wdata  <= mem_wdata_d;
      bus.brk_rdata  <= brk_rdata_d;
      bus.brk_ack    <= brk_ack_d;
    end
  end
endmodule

// File: doc/dbrk_arb.md
Name: dbrk_arb

Overview:
- Data-break arbiter and sequencer for the shared 32K-word memory (3-bit field + 12-bit address).
- Up to NREQ break devices raise requests. The block holds the CPU at its next major-state boundary, grants one device per break cycle in round-robin order, and drives one memory read or write.
- Back-to-back breaks are served while the CPU stays held. The CPU resumes only when no requests remain.

Parameters:
- NREQ, 4, number of break requesters (2..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- state  in  5  CPU major state code, using the shared parameter encoding (F0..F3, D0..D3, E0..E3, H0..H3).
- brk_req  in  NREQ  per-device break request, level.
- brk_write  in  NREQ  per-device direction; 1 = write memory.
- brk_addr  in  15*NREQ  per-device {field[2:0], addr[11:0]}; device i occupies bits 15i+14:15i.
- brk_wdata  in  12*NREQ  per-device write data; device i occupies bits 12i+11:12i.
- mem_rdata  in  12  memory read data, valid the cycle after mem_addr is applied.
- cpu_hold  out  1  stall request to the CPU; the CPU must not leave a boundary state while it is 1.
- brk_active  out  1  arbiter owns the memory bus.
- mem_addr  out  15  break memory address.
- mem_wdata  out  12  break write data.
- mem_we  out  1  memory write strobe.
- brk_ack  out  NREQ  one-hot, one-cycle completion pulse.
- brk_rdata  out  12  read data, valid while brk_ack is high.

Behaviour:
- Reset (asynchronous, while reset=0):
  - FSM=IDLE.
  - cpu_hold=0, brk_active=0, mem_we=0, brk_ack=0.
  - mem_addr=0, mem_wdata=0, brk_rdata=0.
  - Round-robin pointer last=NREQ-1, so device 0 has first priority.
- All outputs are registered.
- Boundary states: F3, D3, E3, H0, H1, H2, H3.
- FSM IDLE:
  - If |brk_req, go to HOLD and set cpu_hold=1.
- FSM HOLD:
  - If state is not a boundary: stay.
  - If state is a boundary and |brk_req: select winner w, go to ADDR.
    - Latch mem_addr=brk_addr[w] and mem_wdata=brk_wdata[w].
    - Latch the write flag from brk_write[w].
    - Set brk_active=1 and last=w.
  - If state is a boundary and no request remains: go to IDLE, cpu_hold=0.
- FSM ADDR:
  - Go to DATA; set mem_we=1 if the latched write flag is 1.
- FSM DATA:
  - Go to ACK; set mem_we=0 and brk_ack[w]=1.
  - For a read, brk_rdata=mem_rdata. For a write, brk_rdata holds mem_wdata.
- FSM ACK:
  - brk_ack returns to 0 next cycle.
  - If any request other than w is pending (brk_req with bit w masked): choose the next winner and go straight to ADDR with cpu_hold kept at 1.
  - Otherwise go to IDLE with cpu_hold=0 and brk_active=0.
  - A request from w itself is served again only after passing through IDLE/HOLD.
- Arbitration:
  - Search starts at (last+1) mod NREQ and wraps.
  - The first set brk_req bit wins.
- Latency:
  - A request seen in IDLE with the CPU already at a boundary gives brk_ack 4 cycles after the request edge (IDLE→HOLD→ADDR→DATA→ACK).
  - mem_we is high for exactly 1 cycle per write.
- Request dropped before grant: ignored. HOLD releases the CPU at the next boundary if nothing is left.
- Request dropped after grant: the transfer still completes using the latched address and data; brk_ack still pulses.
- brk_write, brk_addr and brk_wdata are sampled only at grant; later changes have no effect.
- mem_addr and mem_wdata hold their values after ACK until the next grant.
- Reset mid-break: everything clears immediately; mem_we drops asynchronously and no ack is issued.
- brk_ack is never asserted for more than one device in a cycle.

Test Plan:
- Reset behaviour: drive reset=0 mid-write (state DATA, mem_we=1) → mem_we, cpu_hold, brk_active and brk_ack all 0 asynchronously. After release, the first grant goes to device 0 when devices 0 and 1 request together.
- Single read: brk_req=0001, brk_addr[0]=15'o71234, state=E3, mem_rdata=12'o5252 → cpu_hold at +1, mem_addr=15'o71234 at +2, brk_ack=0001 with brk_rdata=12'o5252 at +4, cpu_hold=0 at +5.
- Single write: device 2 writes 12'o1707 to 15'o00200 → mem_we high for exactly one cycle with mem_wdata=12'o1707. brk_ack=0100 one cycle later.
- Boundary wait: request while state cycles F0..F2 → cpu_hold=1 and no grant until state=F3. The grant happens in the cycle after F3 is seen.
- Round robin: devices 0, 1 and 3 request continuously → grant order 0, 1, 3, 0. Breaks run back-to-back every 3 cycles and cpu_hold stays 1 throughout.
- Late drop: device 1 deasserts brk_req in ADDR → transfer completes and brk_ack=0010 is pulsed. Device 1 drops before grant, with no other request → HOLD returns to IDLE with no mem_we and no ack.
